// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the core's fetch and data ports onto one single-port memory; one transaction at a time.
// Latency: request sampled in IDLE, MREQ the next cycle, ACK one cycle after MREADY (3 cycles zero-wait).
// Backpressure: MREQ and its address/data are held until MREADY; core requests are held until their ACK.
//
// Ports:
//   CLK, RSTN                        clock, asynchronous active-low reset
//   IREQ, IADDR -> INSTR, IACK       instruction-fetch port (read only)
//   DREQ, DRW, DADDR, DWDATA
//                -> DRDATA, DACK     data port (DRW=1 write, 0 read)
//   MREQ, MRW, MADDR, MWDATA
//                <- MRDATA, MREADY   memory side, variable-latency ready handshake
//
// Optional build macro: MEM_PORT_ARB_STARVE_GUARD_EN
//   When defined, a streak counter lets a pending fetch win after DSTREAK
//   consecutive data grants. When undefined, data has strict priority.
//
// Every output comes straight from a flop; the output comb process only
// computes the next values.

module mem_port_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int DSTREAK = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    // instruction-fetch port
    input  logic          IREQ,
    input  logic [AW-1:0] IADDR,
    output logic [DW-1:0] INSTR,
    output logic          IACK,
    // data port
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [AW-1:0] DADDR,
    input  logic [DW-1:0] DWDATA,
    output logic [DW-1:0] DRDATA,
    output logic          DACK,
    // memory port
    output logic          MREQ,
    output logic          MRW,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic [DW-1:0] MRDATA,
    input  logic          MREADY
);

    // A streak limit of zero would let fetch always win, which is never intended.
    if (DSTREAK < 1) begin : g_bad_dstreak
        $error("mem_port_arbiter: DSTREAK must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic starve;       // fetch has waited out its allowed data streak
    logic grant_data;
    logic grant_fetch;
    logic mem_done;     // memory completes the in-flight access this cycle

    // next values of the registered outputs
    logic          mreq_nxt;
    logic          mrw_nxt;
    logic [AW-1:0] maddr_nxt;
    logic [DW-1:0] mwdata_nxt;
    logic [DW-1:0] instr_nxt;
    logic [DW-1:0] drdata_nxt;
    logic          iack_nxt;
    logic          dack_nxt;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(DSTREAK + 1);

    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;

    assign starve = IREQ && (streak == SW'(DSTREAK));

    // Counts data grants that jumped ahead of a waiting fetch. It never
    // passes DSTREAK because at DSTREAK the fetch is granted instead.
    always_comb begin
        streak_nxt = streak;
        if (state == S_IDLE) begin
            if (!IREQ) begin
                streak_nxt = '0;
            end else if (grant_data) begin
                streak_nxt = streak + SW'(1);
            end else if (grant_fetch) begin
                streak_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            streak <= '0;
        end else begin
            streak <= streak_nxt;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    assign grant_data  = (state == S_IDLE) && DREQ && !starve;
    assign grant_fetch = (state == S_IDLE) && IREQ && !grant_data;

    // MREADY outside an active request is ignored.
    assign mem_done    = MREQ && MREADY;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_data) begin
                    state_nxt = S_DBUSY;
                end else if (grant_fetch) begin
                    state_nxt = S_IBUSY;
                end
            end
            S_IBUSY, S_DBUSY: begin
                if (mem_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        mreq_nxt   = MREQ;
        mrw_nxt    = MRW;
        maddr_nxt  = MADDR;
        mwdata_nxt = MWDATA;
        instr_nxt  = INSTR;
        drdata_nxt = DRDATA;
        iack_nxt   = 1'b0;
        dack_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_data) begin
                    mreq_nxt   = 1'b1;
                    mrw_nxt    = DRW;
                    maddr_nxt  = DADDR;
                    mwdata_nxt = DWDATA;
                end else if (grant_fetch) begin
                    // fetches are always reads with a clean write bus
                    mreq_nxt   = 1'b1;
                    mrw_nxt    = 1'b0;
                    maddr_nxt  = IADDR;
                    mwdata_nxt = '0;
                end
            end
            S_IBUSY: begin
                if (mem_done) begin
                    mreq_nxt  = 1'b0;
                    instr_nxt = MRDATA;
                    iack_nxt  = 1'b1;
                end
            end
            S_DBUSY: begin
                if (mem_done) begin
                    mreq_nxt = 1'b0;
                    // a write leaves the last read data in place
                    if (!MRW) begin
                        drdata_nxt = MRDATA;
                    end
                    dack_nxt = 1'b1;
                end
            end
            default: begin
                // RESP: the ACK pulse is already on the outputs; nothing to update
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. Reset clears MREQ asynchronously, abandoning any
    // in-flight access without an acknowledge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            MREQ   <= 1'b0;
            MRW    <= 1'b0;
            MADDR  <= '0;
            MWDATA <= '0;
            INSTR  <= '0;
            DRDATA <= '0;
            IACK   <= 1'b0;
            DACK   <= 1'b0;
        end else begin
            MREQ   <= mreq_nxt;
            MRW    <= mrw_nxt;
            MADDR  <= maddr_nxt;
            MWDATA <= mwdata_nxt;
            INSTR  <= instr_nxt;
            DRDATA <= drdata_nxt;
            IACK   <= iack_nxt;
            DACK   <= dack_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.

module tb_mem_port_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          CLK;
    logic          RSTN;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          IACK;
    logic          DREQ;
    logic          DRW;
    logic [AW-1:0] DADDR;
    logic [DW-1:0] DWDATA;
    logic [DW-1:0] DRDATA;
    logic          DACK;
    logic          MREQ;
    logic          MRW;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [DW-1:0] MRDATA;
    logic          MREADY;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .DSTREAK(4)) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .IREQ   (IREQ),
        .IADDR  (IADDR),
        .INSTR  (INSTR),
        .IACK   (IACK),
        .DREQ   (DREQ),
        .DRW    (DRW),
        .DADDR  (DADDR),
        .DWDATA (DWDATA),
        .DRDATA (DRDATA),
        .DACK   (DACK),
        .MREQ   (MREQ),
        .MRW    (MRW),
        .MADDR  (MADDR),
        .MWDATA (MWDATA),
        .MRDATA (MRDATA),
        .MREADY (MREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          dreq;
        logic          drw;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwdata;
        logic [DW-1:0] mrdata;
        int            waits;       // MREADY=0 cycles before completion
        logic          exp_data;    // 1: data port wins, 0: fetch wins
        logic [AW-1:0] exp_maddr;
        logic          exp_mrw;
        logic [DW-1:0] exp_mwdata;
        logic [DW-1:0] exp_instr;
        logic [DW-1:0] exp_drdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // IACK and DACK must never coincide.
    always @(negedge CLK) begin
        if (RSTN) begin
            checks++;
            if (IACK && DACK) begin
                errors++;
                $display("FAIL ack_exclusive actual=11 required=not_both (t=%0t)", $time);
            end
        end
    end

    // One transaction, entered and left on a falling edge with the DUT in IDLE.
    task automatic do_txn(input vec_t v, input bit early_drop);
        logic [1:0] exp_ack;
        exp_ack = v.exp_data ? 2'b01 : 2'b10;
        IREQ   = v.ireq;
        IADDR  = v.iaddr;
        DREQ   = v.dreq;
        DRW    = v.drw;
        DADDR  = v.daddr;
        DWDATA = v.dwdata;
        MREADY = 1'b0;
        MRDATA = ~v.mrdata;
        @(negedge CLK);  // cycle 1: request on the memory bus
        chk("mreq_up",  {63'd0, MREQ},   64'd1);
        chk("maddr",    {34'd0, MADDR},  {34'd0, v.exp_maddr});
        chk("mrw",      {63'd0, MRW},    {63'd0, v.exp_mrw});
        chk("mwdata",   {32'd0, MWDATA}, {32'd0, v.exp_mwdata});
        chk("ack_busy", {62'd0, IACK, DACK}, 64'd0);
        if (early_drop) begin
            IREQ = 1'b0;
            DREQ = 1'b0;
        end
        for (int w = 0; w <= v.waits; w++) begin
            if (w > 0) begin
                @(negedge CLK);
                chk("mreq_held",  {63'd0, MREQ},  64'd1);
                chk("maddr_held", {34'd0, MADDR}, {34'd0, v.exp_maddr});
                chk("ack_wait",   {62'd0, IACK, DACK}, 64'd0);
            end
            MREADY = (w == v.waits);
            MRDATA = (w == v.waits) ? v.mrdata : ~v.mrdata;
        end
        @(negedge CLK);  // RESP
        chk("mreq_down", {63'd0, MREQ}, 64'd0);
        chk("ack",       {62'd0, IACK, DACK}, {62'd0, exp_ack});
        chk("instr",     {32'd0, INSTR},  {32'd0, v.exp_instr});
        chk("drdata",    {32'd0, DRDATA}, {32'd0, v.exp_drdata});
        MREADY = 1'b0;
        if (v.exp_data) DREQ = 1'b0;
        else            IREQ = 1'b0;
        @(negedge CLK);  // IDLE
        chk("ack_pulse", {62'd0, IACK, DACK}, 64'd0);
    endtask

    vec_t vecs[8];
    vec_t v;
    int   nack;
    int   nwant;
    bit   exp_fetch;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ireq iaddr              dreq drw  daddr              dwdata        mrdata        w  data maddr              mrw  mwdata        instr         drdata
        vecs[0] = '{1'b1, 30'h10,         1'b0, 1'b0, 30'h0,         32'h0,        32'hDEADBEEF, 0, 1'b0, 30'h10,         1'b0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 30'h0,          1'b1, 1'b1, 30'h20,        32'h12345678, 32'hBAD0BAD0, 2, 1'b1, 30'h20,         1'b1, 32'h12345678, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b0, 30'h0,          1'b1, 1'b0, 30'h21,        32'h0,        32'hCAFEF00D, 1, 1'b1, 30'h21,         1'b0, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 30'h30,         1'b1, 1'b0, 30'h40,        32'h0,        32'h11112222, 0, 1'b1, 30'h40,         1'b0, 32'h0,        32'hDEADBEEF, 32'h11112222};
        vecs[4] = '{1'b1, 30'h30,         1'b0, 1'b1, 30'h3FF,       32'hFFFFFFFF, 32'h33334444, 3, 1'b0, 30'h30,         1'b0, 32'h0,        32'h33334444, 32'h11112222};
        vecs[5] = '{1'b1, 30'h3FFFFFFF,   1'b0, 1'b0, 30'h0,         32'h0,        32'hFFFFFFFF, 0, 1'b0, 30'h3FFFFFFF,   1'b0, 32'h0,        32'hFFFFFFFF, 32'h11112222};
        vecs[6] = '{1'b0, 30'h0,          1'b1, 1'b1, 30'h3FFFFFFF,  32'hA5A5A5A5, 32'h0,        0, 1'b1, 30'h3FFFFFFF,   1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h11112222};
        vecs[7] = '{1'b0, 30'h0,          1'b1, 1'b0, 30'h0,         32'h0,        32'h0,        0, 1'b1, 30'h0,          1'b0, 32'h0,        32'hFFFFFFFF, 32'h0};

        RSTN = 1'b0; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0;
        DADDR = '0; DWDATA = '0; MRDATA = '0; MREADY = 1'b0;

        // reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_mreq",   {63'd0, MREQ},   64'd0);
        chk("rst_mrw",    {63'd0, MRW},    64'd0);
        chk("rst_maddr",  {34'd0, MADDR},  64'd0);
        chk("rst_mwdata", {32'd0, MWDATA}, 64'd0);
        chk("rst_instr",  {32'd0, INSTR},  64'd0);
        chk("rst_drdata", {32'd0, DRDATA}, 64'd0);
        chk("rst_acks",   {62'd0, IACK, DACK}, 64'd0);
        RSTN = 1'b1;
        @(negedge CLK);

        // table: fetch, store with waits, load, simultaneous, boundaries
        for (int i = 0; i < 8; i++) begin
            do_txn(vecs[i], 1'b0);
        end

        // MREADY with no request outstanding does nothing
        MREADY = 1'b1;
        MRDATA = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("idle_mready_mreq", {63'd0, MREQ}, 64'd0);
            chk("idle_mready_ack",  {62'd0, IACK, DACK}, 64'd0);
        end
        MREADY = 1'b0;

        // fetch request dropped while in flight still completes
        v = '{1'b1, 30'h55, 1'b0, 1'b0, 30'h0, 32'h0, 32'h5A5A0001, 1, 1'b0, 30'h55, 1'b0, 32'h0, 32'h5A5A0001, 32'h0};
        do_txn(v, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("drop_no_grant", {63'd0, MREQ}, 64'd0);
        end

        // starvation: both requests held, memory always ready
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
        nwant = 20;
`else
        nwant = 50;
`endif
        nack   = 0;
        IREQ   = 1'b1; IADDR = 30'h77;
        DREQ   = 1'b1; DRW = 1'b0; DADDR = 30'h88; DWDATA = 32'h0;
        MRDATA = 32'h600D0000;
        MREADY = 1'b1;
        for (int cyc = 0; cyc < 400 && nack < nwant; cyc++) begin
            @(negedge CLK);
            if (IACK || DACK) begin
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
                exp_fetch = ((nack % 5) == 4);
`else
                exp_fetch = 1'b0;
`endif
                chk("starve_ack", {62'd0, IACK, DACK}, exp_fetch ? 64'd2 : 64'd1);
                nack++;
            end
        end
        chk("starve_count", 64'(nack), 64'(nwant));
        IREQ = 1'b0; DREQ = 1'b0; MREADY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        // reset in the middle of a stalled store
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h99; DWDATA = 32'h5555AAAA;
        @(negedge CLK);
        chk("mid_mreq_up", {63'd0, MREQ}, 64'd1);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        chk("async_mreq",  {63'd0, MREQ},  64'd0);
        chk("async_maddr", {34'd0, MADDR}, 64'd0);
        chk("async_mrw",   {63'd0, MRW},   64'd0);
        DREQ = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_rst_dack", {63'd0, DACK}, 64'd0);
            chk("post_rst_mreq", {63'd0, MREQ}, 64'd0);
        end
        v = '{1'b1, 30'h66, 1'b0, 1'b0, 30'h0, 32'h0, 32'h0F0F0F0F, 0, 1'b0, 30'h66, 1'b0, 32'h0, 32'h0F0F0F0F, 32'h0};
        do_txn(v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory between the core's instruction-fetch port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA). It sits between RISC_TOY and a unified memory macro with a variable-latency ready handshake. Each side gets a one-cycle acknowledge pulse. By default the data port has priority, and an optional streak limit keeps instruction fetch from starving.

## Interface
- AW, 30: word-address width
- DW, 32: data width
- DSTREAK, 4: max consecutive data grants while IREQ is pending (used only with the macro)

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- IREQ  in  1  fetch request, held until IACK
- IADDR  in  AW  fetch word address
- INSTR  out  DW  fetched word, valid while IACK=1, then held
- IACK  out  1  one-cycle fetch completion pulse
- DREQ  in  1  data request, held until DACK
- DRW  in  1  1 = write, 0 = read
- DADDR  in  AW  data word address
- DWDATA  in  DW  write data
- DRDATA  out  DW  read data, valid while DACK=1 after a read, then held
- DACK  out  1  one-cycle data completion pulse
- MREQ  out  1  memory request, held until MREADY
- MRW  out  1  memory write enable
- MADDR  out  AW  memory address
- MWDATA  out  DW  memory write data
- MRDATA  in  DW  memory read data, valid when MREADY=1
- MREADY  in  1  memory completion; sampled only while MREQ=1

## Operation
- FSM states: IDLE, IBUSY, DBUSY, RESP. Requests are sampled only in IDLE.
- In IDLE:
  - DREQ=1 grants data (→DBUSY). This is overridden only when the macro is on, IREQ=1 and streak==DSTREAK.
  - Otherwise IREQ=1 grants fetch (→IBUSY).
  - With neither request, stay in IDLE.
- At grant:
  - MADDR, MRW and MWDATA are registered from the winning port. A fetch forces MRW=0 and MWDATA=0.
  - MREQ goes to 1.
- IBUSY/DBUSY: hold MREQ and the registered MADDR/MRW/MWDATA unchanged until MREADY=1.
- On the MREADY=1 cycle:
  - MRDATA is captured into INSTR (fetch) or DRDATA (data read).
  - A data write leaves DRDATA unchanged.
  - MREQ is cleared, and the FSM moves to RESP.
- RESP:
  - IACK or DACK is driven high for exactly one cycle, matching the port of the transaction just completed.
  - The FSM then returns to IDLE.
  - The core must drop or replace its request at the edge that ends RESP.
- If a core request drops while its transaction is in flight, the transaction still completes and is still acknowledged.
- MREADY while MREQ=0 is ignored.
- IACK and DACK are never high in the same cycle.

## Timing
- Reset values:
  - State is IDLE.
  - MREQ, MRW, IACK and DACK are 0.
  - MADDR, MWDATA, INSTR and DRDATA are 0.
  - The streak counter is 0.
- Reset asserted mid-transaction clears MREQ immediately (asynchronously). The in-flight transaction is abandoned and not acknowledged.
- Zero-wait latency (MREADY=1 in the first MREQ cycle):
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: MREQ=1.
  - Cycle 2: ACK with data.
  - Cycle 3: IDLE, able to sample the next request.
- Peak throughput is one transaction per 3 cycles. Each memory wait state adds one cycle.
- All outputs are registered; there is no combinational path from core or memory inputs to any output.

## Configuration
- MEM_PORT_ARB_STARVE_GUARD_EN defined:
  - A counter of width clog2(DSTREAK+1) increments on every data grant made while IREQ=1.
  - It resets to 0 on a fetch grant, or on any IDLE cycle with IREQ=0.
  - At streak==DSTREAK, a pending IREQ wins over DREQ.
- Undefined: strict data priority and no counter. A continuously asserted DREQ starves IREQ indefinitely.

## Test plan
- Single fetch, zero-wait: IREQ=1, IADDR=0x10, MRDATA=0xDEADBEEF with MREADY in the first MREQ cycle → MADDR=0x10 and MRW=0 in cycle 1; IACK=1 and INSTR=0xDEADBEEF in cycle 2.
- Store with 2 wait states: DREQ=1, DRW=1, DADDR=0x20, DWDATA=0x12345678 → MREQ held 3 cycles with MRW=1 and MWDATA=0x12345678; DACK 1 cycle later; DRDATA unchanged.
- Simultaneous requests: IREQ=DREQ=1 in IDLE, DRW=0 → data served first (DACK, DRDATA=MRDATA), then fetch (IACK); never both ACKs in one cycle.
- Starvation: macro on, DSTREAK=4, IREQ and DREQ both held high, DREQ re-asserted after each DACK → exactly 4 DACKs, then 1 IACK, repeating. Macro off → no IACK over 50 data transactions.
- Reset mid-transaction: drop RSTN while in DBUSY with MREADY=0 → MREQ=0 before the next edge; no DACK after release; the first grant after reset starts from IDLE.
- Late request drop: IREQ drops while in IBUSY → transaction still completes and IACK still pulses; next IDLE grants nothing.
